tmds_encoder: RTL
=================

TMDS_ENCODER -- requirements
Module: tmds_encoder

Interface
REQ-001 SHALL have parameter none; configuration is by macro only (REQ-024).
REQ-002 SHALL have port sys_clk  input  1  pixel clock; all state changes on its rising edge.
REQ-003 SHALL have port sys_rst  input  1  reset; asynchronous assert, active-high, one clock domain (sys_clk).
REQ-004 SHALL have port din  input  8  pixel colour component.
REQ-005 SHALL have port de  input  1  data enable; 1 = active video, 0 = blanking.
REQ-006 SHALL have port c0  input  1  control bit 0, HSYNC on the blue channel.
REQ-007 SHALL have port c1  input  1  control bit 1, VSYNC on the blue channel.
REQ-008 SHALL have port dout  output  10  TMDS symbol, registered, LSB transmitted first, feeds the 10:1 serializer.

Function
REQ-009 SHALL implement DVI 1.0 8b/10b TMDS encoding: transition minimisation, then DC balancing.
REQ-010 Stage 1 SHALL register din, de, c0, c1 and n1d, the 4-bit ones-count of din.
REQ-011 Stage 2 SHALL form q_m: q_m[0]=din[0]; XNOR chain with q_m[8]=0 when n1d>4 or (n1d==4 and din[0]==0); otherwise XOR chain with q_m[8]=1.
REQ-012 Stage 2 SHALL register q_m[8:0], n1q and n0q (ones and zeros count of q_m[7:0]), de, c0 and c1.
REQ-013 The running disparity cnt SHALL be a signed 5-bit register internal to the output stage.
REQ-014 de=0 SHALL force cnt:=0 and dout by {c1,c0}: 00->10'h354, 01->10'h0AB, 10->10'h154, 11->10'h2AB.
REQ-015 de=1 with (cnt==0 or n1q==n0q): dout={~q_m[8], q_m[8], q_m[8]?q_m[7:0]:~q_m[7:0]}; cnt:=cnt+(q_m[8]?n1q-n0q:n0q-n1q).
REQ-016 de=1 with ((cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q)): dout={1, q_m[8], ~q_m[7:0]}; cnt:=cnt+2*q_m[8]+(n0q-n1q).
REQ-017 de=1 in all other cases: dout={0, q_m[8], q_m[7:0]}; cnt:=cnt-2*(~q_m[8])+(n1q-n0q).
REQ-018 Disparity arithmetic SHALL be signed, at least 5 bits, with counts sign-extended before use; no wrap occurs for legal streams.
REQ-019 Latency SHALL be 2 clocks: inputs sampled at edge k appear on dout after edge k+2; throughput is one symbol per clock with no stalls.
REQ-020 A de transition SHALL take effect on exactly the symbol of its sample; no symbol is dropped or duplicated.

Reset
REQ-021 Asserting sys_rst SHALL immediately clear all pipeline registers, cnt and dout to 0, without waiting for a clock edge.
REQ-022 After deassertion, the first 2 dout values SHALL reflect the cleared pipeline (de=0, c=00 -> 10'h354); valid encoding follows.
REQ-023 Reset mid-stream SHALL discard in-flight symbols; the next data symbol encodes as if cnt==0.

Configuration
REQ-024 Macro TMDS_ENCODER_OUTREG_EN defined SHALL add one extra register after the output stage; latency becomes 3 clocks and that register is also reset to 0.
REQ-025 Macro TMDS_ENCODER_OUTREG_EN undefined SHALL give latency 2 clocks; symbol values are identical in both builds.

Verification
REQ-026 Reset: assert sys_rst between edges -> dout=0 immediately; release -> 10'h354 within 2 clocks.
REQ-027 Control: de=0, {c1,c0}=00,01,10,11 on successive clocks -> dout 10'h354, 10'h0AB, 10'h154, 10'h2AB, 2 clocks later.
REQ-028 Balance: de=1, din=8'h00 repeated from cnt=0 -> dout 10'h100, 10'h3FF, 10'h100, 10'h3FF, with cnt -8, +2, -6, +4.
REQ-029 XNOR path: de=1, din=8'hFF from cnt=0 -> dout 10'h200, cnt=-8.
REQ-030 Blanking resets disparity: run REQ-028 for 3 symbols, one de=0 cycle, then din=8'h00 -> 10'h100.
REQ-031 Mid-stream reset plus macro build: repeat REQ-028 with TMDS_ENCODER_OUTREG_EN -> same values, 1 clock later; reset pulse mid-stream -> next data symbol 10'h100.

Source files
------------

// File: rtl/tmds_encoder.sv
// DVI 8b/10b TMDS channel encoder: ones-count, transition-minimise, DC-balance.
// Define TMDS_ENCODER_OUTREG_EN to add a retiming register on dout (latency 3).
module tmds_encoder (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] din,
  input  logic       de,
  input  logic       c0,
  input  logic       c1,
  output logic [9:0] dout
);

  typedef struct packed {
    logic de;
    logic c1;
    logic c0;
  } ctl_t;

  ctl_t              r_ctl1, r_ctl2;
  logic [7:0]        r_din;
  logic [3:0]        r_n1d, r_n1q, r_n0q;
  logic [8:0]        r_qm;
  logic signed [4:0] r_cnt;
  logic [9:0]        r_dout;

  logic [3:0]        w_n1d, w_n1q;
  logic [8:0]        w_qm;
  logic              w_xnor;
  logic signed [4:0] w_n1s, w_n0s, w_diff, w_two, w_cnt_nxt;
  logic [9:0]        w_dout_nxt;

  always_comb begin
    w_n1d = '0;
    for (int i = 0; i < 8; i++) w_n1d = w_n1d + {3'b000, din[i]};
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_din  <= '0;
      r_n1d  <= '0;
      r_ctl1 <= '0;
    end else begin
      r_din  <= din;
      r_n1d  <= w_n1d;
      r_ctl1 <= '{de: de, c1: c1, c0: c0};
    end
  end

  // XNOR chain whenever it yields fewer transitions; q_m[8] records the choice.
  always_comb begin
    logic [8:0] qm;
    w_xnor = (r_n1d > 4'd4) || ((r_n1d == 4'd4) && !r_din[0]);
    qm     = '0;
    qm[0]  = r_din[0];
    for (int i = 1; i < 8; i++)
      qm[i] = w_xnor ? ~(qm[i-1] ^ r_din[i]) : (qm[i-1] ^ r_din[i]);
    qm[8]  = ~w_xnor;
    w_qm   = qm;
    w_n1q  = '0;
    for (int i = 0; i < 8; i++) w_n1q = w_n1q + {3'b000, qm[i]};
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_qm   <= '0;
      r_n1q  <= '0;
      r_n0q  <= '0;
      r_ctl2 <= '0;
    end else begin
      r_qm   <= w_qm;
      r_n1q  <= w_n1q;
      r_n0q  <= 4'd8 - w_n1q;
      r_ctl2 <= r_ctl1;
    end
  end

  always_comb begin
    w_n1s      = signed'({1'b0, r_n1q});
    w_n0s      = signed'({1'b0, r_n0q});
    w_diff     = w_n1s - w_n0s;
    w_two      = r_qm[8] ? 5'sd2 : 5'sd0;
    w_cnt_nxt  = r_cnt;
    w_dout_nxt = 10'h354;
    if (!r_ctl2.de) begin
      w_cnt_nxt = 5'sd0;
      case ({r_ctl2.c1, r_ctl2.c0})
        2'b00:   w_dout_nxt = 10'h354;
        2'b01:   w_dout_nxt = 10'h0AB;
        2'b10:   w_dout_nxt = 10'h154;
        default: w_dout_nxt = 10'h2AB;
      endcase
    end else if ((r_cnt == 5'sd0) || (r_n1q == r_n0q)) begin
      w_dout_nxt = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
      w_cnt_nxt  = r_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
    end else if (((r_cnt > 5'sd0) && (r_n1q > r_n0q)) ||
                 ((r_cnt < 5'sd0) && (r_n0q > r_n1q))) begin
      w_dout_nxt = {1'b1, r_qm[8], ~r_qm[7:0]};
      w_cnt_nxt  = r_cnt + w_two - w_diff;
    end else begin
      // Inverted-sense correction: 2 is charged only when q_m[8] is clear.
      w_dout_nxt = {1'b0, r_qm[8], r_qm[7:0]};
      w_cnt_nxt  = r_cnt - (5'sd2 - w_two) + w_diff;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt  <= '0;
      r_dout <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_dout <= w_dout_nxt;
    end
  end

`ifdef TMDS_ENCODER_OUTREG_EN
  logic [9:0] r_dout_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_dout_q <= '0;
    else         r_dout_q <= r_dout;
  end

  assign dout = r_dout_q;
`else
  assign dout = r_dout;
`endif

endmodule
